// File: rtl/rr_arbiter_5_onehot_if.sv
// Request/grant bundle between five requesters and the round-robin arbiter.
// The release pulse is carried as 'rel' because 'release' is a reserved word in SystemVerilog.
interface rr_arbiter_5_onehot_if;
    logic [4:0] req;
    logic       rel;
    logic [4:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    modport master (output req, rel, input gnt, gnt_valid, timeout);
    modport slave  (input req, rel, output gnt, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter_5_onehot.sv
// Five-requester round-robin arbiter with grant lock and registered one-hot grant.
// Optional hold-time limit with forced release is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_5_onehot #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_arbiter_5_onehot_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_n;
    logic [4:0] gnt_q, gnt_n;
    logic [2:0] ptr, ptr_n;
    logic       timeout_q, timeout_n;
    logic [4:0] cand;
    logic [3:0] idx;
    logic       found;
    logic [2:0] win;
    logic       owner_done;
    logic       force_end;

    if (2**CNT_W <= HOLD_MAX) begin : g_cnt_check
        $error("CNT_W too narrow for HOLD_MAX");
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    assign force_end = (state == GRANT) && (cnt == CNT_W'(HOLD_MAX));

    // Counter restarts on every freshly loaded grant; owners always differ back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state_n == GRANT && gnt_n != gnt_q)
            cnt <= '0;
        else if (state == GRANT)
            cnt <= cnt + 1'b1;
    end
`else
    assign force_end = 1'b0;
`endif

    assign owner_done = bus.rel | ~(|(bus.req & gnt_q));

    // The current owner never competes on the edge its grant ends.
    always_comb begin
        cand  = (state == GRANT) ? (bus.req & ~gnt_q) : bus.req;
        found = 1'b0;
        win   = ptr;
        idx   = 4'd0;
        for (int i = 0; i < 5; i++) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'd5)
                idx = idx - 4'd5;
            if (!found && cand[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt_q;
        ptr_n     = ptr;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = 5'd1 << win;
                    ptr_n   = (win == 3'd4) ? 3'd0 : win + 3'd1;
                end
            end
            GRANT: begin
                if (owner_done || force_end) begin
                    timeout_n = force_end & ~owner_done;
                    if (found) begin
                        gnt_n = 5'd1 << win;
                        ptr_n = (win == 3'd4) ? 3'd0 : win + 3'd1;
                    end else begin
                        gnt_n   = 5'd0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_q     <= 5'd0;
            ptr       <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            gnt_q     <= gnt_n;
            ptr       <= ptr_n;
            timeout_q <= timeout_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_5_onehot.sv
// Directed bench for rr_arbiter_5_onehot: a behavioural round-robin model checked
// every cycle, plus literal expectations; honours ARB_TIMEOUT_EN like the design.
module tb_rr_arbiter_5_onehot;

    localparam int HOLD_MAX = 15;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    rr_arbiter_5_onehot_if bus ();

    rr_arbiter_5_onehot #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_to;

    function automatic int pick(input logic [4:0] r, input int ptr, input int excl);
        for (int off = 0; off < 5; off++) begin
            int k;
            k = (ptr + off) % 5;
            if (k != excl && r[k])
                return k;
        end
        return -1;
    endfunction

    // Reference: owner index (-1 when idle), priority pointer and hold age.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_cnt   <= 0;
            m_to    <= 1'b0;
        end else begin
            int  w;
            bit  ended;
            bit  forced;
            m_to <= 1'b0;
            if (m_owner < 0) begin
                w = pick(bus.req, m_ptr, -1);
                if (w >= 0) begin
                    m_owner <= w;
                    m_ptr   <= (w + 1) % 5;
                    m_cnt   <= 0;
                end
            end else begin
                ended  = bus.rel || !bus.req[m_owner];
                forced = TIMEOUT_ON && (m_cnt == HOLD_MAX);
                m_cnt <= m_cnt + 1;
                if (ended || forced) begin
                    m_to <= forced && !ended;
                    w = pick(bus.req, m_ptr, m_owner);
                    if (w >= 0) begin
                        m_owner <= w;
                        m_ptr   <= (w + 1) % 5;
                        m_cnt   <= 0;
                    end else begin
                        m_owner <= -1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [4:0] exp_gnt;
            exp_gnt = (m_owner < 0) ? 5'd0 : 5'(1 << m_owner);
            vectors++;
            if (bus.gnt !== exp_gnt || bus.gnt_valid !== (m_owner >= 0) || bus.timeout !== m_to) begin
                miscompares++;
                $display("[TB] FAIL model_compare t=%0t got gnt=%b valid=%b timeout=%b, want gnt=%b valid=%b timeout=%b",
                         $time, bus.gnt, bus.gnt_valid, bus.timeout, exp_gnt, (m_owner >= 0), m_to);
            end
        end
    end

    task automatic apply_stimulus(input logic [4:0] r, input logic rl);
        bus.req = r;
        bus.rel = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [4:0] exp_gnt, input logic exp_to);
        vectors++;
        if (bus.gnt !== exp_gnt || bus.gnt_valid !== (|exp_gnt) || bus.timeout !== exp_to) begin
            miscompares++;
            $display("[TB] FAIL %s got gnt=%b valid=%b timeout=%b, want gnt=%b valid=%b timeout=%b",
                     name, bus.gnt, bus.gnt_valid, bus.timeout, exp_gnt, |exp_gnt, exp_to);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 5'd0;
        bus.rel = 1'b0;
        #1;
        check_output("reset_state", 5'b00000, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [4:0] seq [6];
        vectors     = 0;
        miscompares = 0;
        seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};

        do_reset();
        apply_stimulus(5'b10100, 1'b0);
        check_output("first_grant_lowest", 5'b00100, 1'b0);
        apply_stimulus(5'b00000, 1'b1);
        check_output("release_to_idle", 5'b00000, 1'b0);

        // Full rotation with a release every cycle: no idle bubble between owners.
        do_reset();
        apply_stimulus(5'b11111, 1'b0);
        check_output("rotate_0", seq[0], 1'b0);
        for (int i = 1; i < 6; i++) begin
            apply_stimulus(5'b11111, 1'b1);
            check_output($sformatf("rotate_%0d", i), seq[i], 1'b0);
        end

        apply_stimulus(5'b00100, 1'b0);
        check_output("owner_drop_handoff", 5'b00100, 1'b0);
        apply_stimulus(5'b00100, 1'b1);
        check_output("owner_excluded", 5'b00000, 1'b0);
        apply_stimulus(5'b00100, 1'b0);
        check_output("owner_regrant", 5'b00100, 1'b0);

        apply_stimulus(5'b00010, 1'b0);
        check_output("wrap_to_1", 5'b00010, 1'b0);
        apply_stimulus(5'b01000, 1'b0);
        check_output("drop_req_owner_1", 5'b01000, 1'b0);
        apply_stimulus(5'b11111, 1'b0);
        check_output("lock_ignores_others", 5'b01000, 1'b0);
        apply_stimulus(5'b00000, 1'b0);
        check_output("drop_to_idle", 5'b00000, 1'b0);
        apply_stimulus(5'b00000, 1'b1);
        check_output("release_in_idle", 5'b00000, 1'b0);

        do_reset();
        apply_stimulus(5'b00001, 1'b0);
        check_output("hold_start", 5'b00001, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            apply_stimulus(5'b10001, 1'b0);
            check_output($sformatf("hold_%0d", k), 5'b00001, 1'b0);
        end
        apply_stimulus(5'b10001, 1'b0);
        check_output("forced_release", 5'b10000, 1'b1);
        apply_stimulus(5'b10001, 1'b0);
        check_output("timeout_one_cycle", 5'b10000, 1'b0);
`else
        for (int k = 1; k <= 100; k++) begin
            apply_stimulus(5'b10001, 1'b0);
            check_output($sformatf("hold_%0d", k), 5'b00001, 1'b0);
        end
`endif

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_mid_grant", 5'b00000, 1'b0);
        bus.req = 5'b11000;
        bus.rel = 1'b0;
        #3;
        rst_n = 1'b1;
        apply_stimulus(5'b11000, 1'b0);
        check_output("grant_after_reset", 5'b01000, 1'b0);
        apply_stimulus(5'b11000, 1'b1);
        check_output("ptr_after_reset", 5'b10000, 1'b0);
        apply_stimulus(5'b11000, 1'b1);
        check_output("ptr_wrap_4_to_0", 5'b01000, 1'b0);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
